jk_drive_seq: RTL and testbench



---
 rtl/jk_drive_seq.sv | 176 +++++++++++++++++
 tb/tb_jk_drive_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: command-driven excitation sequencer for a bank of WIDTH JK flops.
// Accepts hold/load/count-up/count-down commands. Each step drives J/K for one
// cycle (DRIVE), then holds the bank for one cycle (CHECK). During CHECK the
// q readback is compared against the step target.
// Optional feature macro: JK_DRIVE_TOGGLE_EN. When defined, changing bits are
// driven with j=k=1 (toggle) instead of set/reset excitation.
module jk_drive_seq #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] exp_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] e_q, e_d;       // expected bank state (last verified)
  logic [WIDTH-1:0] n_q, n_d;       // target of the step in flight
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             mism_q, mism_d;

  logic [WIDTH-1:0] ex_base, ex_tgt; // excitation source/target for the next step
  logic [WIDTH-1:0] j_nx, k_nx;
  logic [LEN_W-1:0] acc_steps;

  // Next target of a step given the state it starts from.
  function automatic logic [WIDTH-1:0] step_target(input logic [1:0]       op,
                                                   input logic [WIDTH-1:0] base,
                                                   input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] t;
    case (op)
      OP_LOAD: t = data;
      OP_UP:   t = base + WIDTH'(1);
      OP_DOWN: t = base - WIDTH'(1);
      default: t = base;
    endcase
    return t;
  endfunction

  // Load is a single step; hold and zero-length counts complete without driving.
  assign acc_steps = (cmd_op == OP_LOAD) ? LEN_W'(1) :
                     (cmd_op[1] ? cmd_len : '0);

  // Select where the next step starts: fresh readback at accept, else the
  // target just verified in CHECK.
  always_comb begin
    ex_base = q_fb;
    ex_tgt  = step_target(cmd_op, q_fb, cmd_data);
    if (state_q == CHECK) begin
      ex_base = n_q;
      ex_tgt  = step_target(op_q, n_q, n_q);
    end
  end

`ifdef JK_DRIVE_TOGGLE_EN
  // Changing bits toggle; unchanged bits hold.
  assign j_nx = ex_base ^ ex_tgt;
  assign k_nx = ex_base ^ ex_tgt;
`else
  // Changing bits are set (0->1) or reset (1->0); unchanged bits hold.
  assign j_nx = ~ex_base &  ex_tgt;
  assign k_nx =  ex_base & ~ex_tgt;
`endif

  // Next-state and registered-output logic of the IDLE/DRIVE/CHECK sequencer.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    n_d     = n_q;
    op_d    = op_q;
    steps_d = steps_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    mism_d  = mism_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // Bank has no reset: resync expectation to readback on every command.
          e_d     = q_fb;
          mism_d  = 1'b0;
          op_d    = cmd_op;
          steps_d = acc_steps;
          n_d     = ex_tgt;
          if (acc_steps == '0) begin
            done_d = 1'b1;
          end else begin
            j_d     = j_nx;
            k_d     = k_nx;
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        // Bank samples j/k at this edge; drive returns to hold for CHECK.
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == n_q) begin
          e_d     = n_q;
          steps_d = steps_q - LEN_W'(1);
          if (steps_q != LEN_W'(1)) begin
            n_d     = ex_tgt;
            j_d     = j_nx;
            k_d     = k_nx;
            state_d = DRIVE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          // Failed readback: abandon remaining steps, keep pre-step E.
          mism_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_q     <= '0;
      n_q     <= '0;
      op_q    <= OP_HOLD;
      steps_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      n_q     <= n_d;
      op_q    <= op_d;
      steps_q <= steps_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      mism_q  <= mism_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign exp_q     = e_q;
  assign done      = done_q;
  assign mismatch  = mism_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed bench for jk_drive_seq with a behavioural JK bank on q_fb.
module tb_jk_drive_seq;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
`ifdef JK_DRIVE_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j, k, exp_q;
  logic             busy, done, mismatch;

  logic [WIDTH-1:0] bank_q = '0;
  logic             preset_en = 1'b0;
  logic [WIDTH-1:0] preset_val = '0;
  logic [WIDTH-1:0] stuck0 = '0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Behavioural JK bank, optionally preset by the bench; stuck-at-0 on readback.
  always @(posedge clk) begin
    if (preset_en) bank_q <= preset_val;
    else
      for (int b = 0; b < WIDTH; b++)
        case ({j[b], k[b]})
          2'b10: bank_q[b] <= 1'b1;
          2'b01: bank_q[b] <= 1'b0;
          2'b11: bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
  end
  assign q_fb = bank_q & ~stuck0;

  jk_drive_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .q_fb(q_fb),
    .j(j), .k(k), .exp_q(exp_q), .busy(busy), .done(done), .mismatch(mismatch)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    preset_en = 1'b1; preset_val = v;
    tick();
    preset_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if ({j, k, exp_q} !== 12'h000) $display("FAIL reset_jk_exp: got %h want 000", {j, k, exp_q}); else passed++;
    total++; if ({busy, done, mismatch} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, mismatch}); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_load;
    preset(4'h3);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'hA;
    tick();                        // accept
    cmd_valid = 1'b0;
    total++; if (j !== (TOG ? 4'h9 : 4'h8)) $display("FAIL load_j: got %h want %h", j, TOG ? 4'h9 : 4'h8); else passed++;
    total++; if (k !== (TOG ? 4'h9 : 4'h1)) $display("FAIL load_k: got %h want %h", k, TOG ? 4'h9 : 4'h1); else passed++;
    total++; if ({busy, cmd_ready} !== 2'b10) $display("FAIL load_busy: got %b want 10", {busy, cmd_ready}); else passed++;
    tick();                        // CHECK
    total++; if ({j, k} !== 8'h00) $display("FAIL load_check_hold: got %h want 00", {j, k}); else passed++;
    tick();                        // cycle 3 after accept
    total++; if ({done, busy, mismatch} !== 3'b100) $display("FAIL load_done: got %b want 100", {done, busy, mismatch}); else passed++;
    total++; if (exp_q !== 4'hA) $display("FAIL load_expq: got %h want a", exp_q); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL load_done_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_count_up_wrap;
    logic [3:0] ee [1:8] = '{4'hE, 4'hE, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1};
    logic [3:0] ej [1:8] = '{4'h1, 4'h0, TOG ? 4'hF : 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [3:0] ek [1:8] = '{TOG ? 4'h1 : 4'h0, 4'h0, 4'hF, 4'h0, TOG ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0};
    logic       eb [1:8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ed [1:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    preset(4'hE);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if ({busy, done, exp_q, j, k} !== {eb[c], ed[c], ee[c], ej[c], ek[c]})
        $display("FAIL up_wrap_c%0d: got b%b d%b e%h j%h k%h want b%b d%b e%h j%h k%h",
                 c, busy, done, exp_q, j, k, eb[c], ed[c], ee[c], ej[c], ek[c]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_count_down_wrap;
    preset(4'h0);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 8'd1;
    tick();
    cmd_valid = 1'b0;
    total++; if ({j, k} !== (TOG ? 8'hFF : 8'hF0)) $display("FAIL down_jk: got %h want %h", {j, k}, TOG ? 8'hFF : 8'hF0); else passed++;
    tick(); tick();
    total++; if ({done, exp_q} !== 5'h1F) $display("FAIL down_done_expq: got %h want 1f", {done, exp_q}); else passed++;
    tick();
  endtask

  task automatic test_mismatch;
    stuck0 = 4'h4;
    preset(4'h3);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 8'd4;
    tick();
    cmd_valid = 1'b0;
    total++; if ({j, k} !== (TOG ? 8'h77 : 8'h43)) $display("FAIL mm_jk: got %h want %h", {j, k}, TOG ? 8'h77 : 8'h43); else passed++;
    tick(); tick();
    total++; if ({done, mismatch, busy} !== 3'b110) $display("FAIL mm_flags: got %b want 110", {done, mismatch, busy}); else passed++;
    total++; if (exp_q !== 4'h3) $display("FAIL mm_expq: got %h want 3", exp_q); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({busy, done, mismatch, j, k} !== {3'b001, 8'h00})
        $display("FAIL mm_after_c%0d: got %h want %h", c, {busy, done, mismatch, j, k}, {3'b001, 8'h00});
      else passed++;
    end
    stuck0 = 4'h0;                 // bank holds 4 internally
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    cmd_valid = 1'b0;
    total++; if ({done, mismatch, exp_q} !== 6'h24) $display("FAIL mm_clear: got %h want 24", {done, mismatch, exp_q}); else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    preset(4'h7);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();                        // hold accepted
    total++; if ({done, cmd_ready, busy, exp_q} !== 7'h67) $display("FAIL b2b_hold: got %h want 67", {done, cmd_ready, busy, exp_q}); else passed++;
    cmd_op = 2'b10; cmd_len = 8'd0;
    tick();                        // zero-length count accepted
    total++; if ({done, cmd_ready, busy} !== 3'b110) $display("FAIL b2b_cnt0: got %b want 110", {done, cmd_ready, busy}); else passed++;
    cmd_op = 2'b01; cmd_data = 4'h5;
    tick();                        // load accepted at edge ending done cycle
    total++; if ({busy, done, j, k} !== {2'b10, TOG ? 8'h22 : 8'h02}) $display("FAIL b2b_load_drive: got %h want %h", {busy, done, j, k}, {2'b10, TOG ? 8'h22 : 8'h02}); else passed++;
    cmd_data = 4'hF;               // valid still high while busy: ignored
    tick();
    total++; if ({busy, exp_q} !== 5'h17) $display("FAIL b2b_busy_ignore: got %h want 17", {busy, exp_q}); else passed++;
    cmd_valid = 1'b0;
    tick();
    total++; if ({done, exp_q} !== 5'h15) $display("FAIL b2b_load_done: got %h want 15", {done, exp_q}); else passed++;
    tick();
    total++; if ({busy, done, exp_q} !== 6'h05) $display("FAIL b2b_settle: got %h want 05", {busy, done, exp_q}); else passed++;
  endtask

  task automatic test_reset_mid;
    preset(4'h0);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 8'd5;
    tick();                        // first DRIVE
    cmd_valid = 1'b0;
    tick(); tick();                // second DRIVE
    total++; if ({busy, j} !== 5'h12) $display("FAIL mid_second_drive: got %h want 12", {busy, j}); else passed++;
    rst_n = 1'b0;
    tick();
    total++; if ({j, k, exp_q} !== 12'h000) $display("FAIL mid_rst_jk_exp: got %h want 000", {j, k, exp_q}); else passed++;
    total++; if ({busy, done, cmd_ready} !== 3'b001) $display("FAIL mid_rst_flags: got %b want 001", {busy, done, cmd_ready}); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if ({busy, done} !== 2'b00) $display("FAIL mid_rst_after: got %b want 00", {busy, done}); else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_count_up_wrap();
    test_count_down_wrap();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
